// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline hazard detection, flush and mul/div stall control
module hazard_stall_unit #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_IsBranch,
  input  logic        EX_BranchTaken,
  input  logic        EX_MulDivStart,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Write,
  output logic        IDEX_Bubble,
  output logic        Busy,
  output logic [15:0] StallCycles
);

  typedef enum logic {
    ST_RUN,
    ST_MULDIV_WAIT
  } state_t;

  // Cnt holds the remaining frozen cycles; the wait ends on the edge where it reads 1.
  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_stall_cycles;

  logic w_ex_rs_match;
  logic w_ex_rt_match;
  logic w_mem_rs_match;
  logic w_mem_rt_match;
  logic w_load_use;
  logic w_branch_haz;
  logic w_hazard;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  assign w_ex_rs_match  = (EX_WriteReg  != 5'd0) && (EX_WriteReg  == ID_Rs);
  assign w_ex_rt_match  = (EX_WriteReg  != 5'd0) && (EX_WriteReg  == ID_Rt);
  assign w_mem_rs_match = (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ID_Rs);
  assign w_mem_rt_match = (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ID_Rt);

  assign w_load_use   = EX_MemRead && (w_ex_rs_match || (ID_UsesRt && w_ex_rt_match));
  // Branches compare in ID, so any producer still in EX, or a load still in MEM, is too late to forward.
  assign w_branch_haz = ID_IsBranch &&
                        ((EX_RegWrite && (w_ex_rs_match || w_ex_rt_match)) ||
                         (MEM_MemRead && (w_mem_rs_match || w_mem_rt_match)));
  assign w_hazard     = w_load_use || w_branch_haz;

  assign StallCycles = r_stall_cycles;

  // Pipeline enables: reset, then mul/div freeze, then flush, then hazard stall.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    Busy        = 1'b0;
    if (Reset) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Write  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (r_state == ST_MULDIV_WAIT) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      Busy        = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (w_hazard) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  // Mul/div occupancy FSM; a taken branch kills the mul/div entering EX.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (EX_MulDivStart && !EX_BranchTaken) begin
            r_state <= ST_MULDIV_WAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_MULDIV_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cycles <= 16'd0;
    end else if (!PC_Write && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed vector bench for hazard_stall_unit
module tb_hazard_stall_unit;

  logic        Clk;
  logic        Reset;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [4:0]  EX_WriteReg;
  logic        MEM_MemRead;
  logic [4:0]  MEM_WriteReg;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_IsBranch;
  logic        EX_BranchTaken;
  logic        EX_MulDivStart;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Write;
  logic        IDEX_Bubble;
  logic        Busy;
  logic [15:0] StallCycles;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_sc;

  typedef struct {
    string      name;
    logic       ex_memrd;
    logic       ex_regwr;
    logic [4:0] ex_wr;
    logic       mem_memrd;
    logic [4:0] mem_wr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_br;
    logic       taken;
    logic       e_pcw;
    logic       e_ifw;
    logic       e_flush;
    logic       e_idw;
    logic       e_bub;
  } vec_t;

  vec_t vecs[13];

  hazard_stall_unit #(.MULDIV_CYCLES(4)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_WriteReg    (EX_WriteReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_WriteReg   (MEM_WriteReg),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_IsBranch    (ID_IsBranch),
    .EX_BranchTaken (EX_BranchTaken),
    .EX_MulDivStart (EX_MulDivStart),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Write     (IDEX_Write),
    .IDEX_Bubble    (IDEX_Bubble),
    .Busy           (Busy),
    .StallCycles    (StallCycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    EX_MemRead     = 1'b0;
    EX_RegWrite    = 1'b0;
    EX_WriteReg    = 5'd0;
    MEM_MemRead    = 1'b0;
    MEM_WriteReg   = 5'd0;
    ID_Rs          = 5'd0;
    ID_Rt          = 5'd0;
    ID_UsesRt      = 1'b0;
    ID_IsBranch    = 1'b0;
    EX_BranchTaken = 1'b0;
    EX_MulDivStart = 1'b0;
  endtask

  // Called just after a falling edge with inputs already set: checks the
  // combinational outputs, clocks once, then checks the stall counter.
  task automatic step(input string name, input logic pcw, input logic ifw, input logic fl,
                      input logic idw, input logic bub, input logic busy);
    #1;
    check({name, ".PC_Write"},    {15'd0, PC_Write},    {15'd0, pcw});
    check({name, ".IFID_Write"},  {15'd0, IFID_Write},  {15'd0, ifw});
    check({name, ".IFID_Flush"},  {15'd0, IFID_Flush},  {15'd0, fl});
    check({name, ".IDEX_Write"},  {15'd0, IDEX_Write},  {15'd0, idw});
    check({name, ".IDEX_Bubble"}, {15'd0, IDEX_Bubble}, {15'd0, bub});
    check({name, ".Busy"},        {15'd0, Busy},        {15'd0, busy});
    @(posedge Clk);
    if (Reset) exp_sc = 16'd0;
    else if (!pcw && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    #1;
    check({name, ".StallCycles"}, StallCycles, exp_sc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sc   = 16'd0;

    //          name          exmr exrw exwr  mmr  mwr   rs    rt    urt  br   tk    pcw ifw fl  idw bub
    vecs[0]  = '{"idle",      0,   0,   5'd0, 0,   5'd0, 5'd0, 5'd0, 0,   0,   0,    1,  1,  0,  1,  0};
    vecs[1]  = '{"ld_use_rs", 1,   1,   5'd8, 0,   5'd0, 5'd8, 5'd0, 0,   0,   0,    0,  0,  0,  1,  1};
    vecs[2]  = '{"r0_guard",  1,   1,   5'd0, 0,   5'd0, 5'd0, 5'd0, 0,   0,   0,    1,  1,  0,  1,  0};
    vecs[3]  = '{"ld_use_rt", 1,   1,   5'd5, 0,   5'd0, 5'd1, 5'd5, 1,   0,   0,    0,  0,  0,  1,  1};
    vecs[4]  = '{"rt_unused", 1,   1,   5'd5, 0,   5'd0, 5'd1, 5'd5, 0,   0,   0,    1,  1,  0,  1,  0};
    vecs[5]  = '{"br_ex_alu", 0,   1,   5'd7, 0,   5'd0, 5'd7, 5'd2, 0,   1,   0,    0,  0,  0,  1,  1};
    vecs[6]  = '{"br_mem_ld", 0,   0,   5'd0, 1,   5'd9, 5'd3, 5'd9, 1,   1,   0,    0,  0,  0,  1,  1};
    vecs[7]  = '{"br_mem_alu",0,   0,   5'd0, 0,   5'd9, 5'd3, 5'd9, 1,   1,   0,    1,  1,  0,  1,  0};
    vecs[8]  = '{"alu_nobr",  0,   1,   5'd7, 0,   5'd0, 5'd7, 5'd0, 0,   0,   0,    1,  1,  0,  1,  0};
    vecs[9]  = '{"flush_ld",  1,   1,   5'd8, 0,   5'd0, 5'd8, 5'd0, 0,   0,   1,    1,  1,  1,  1,  1};
    vecs[10] = '{"flush",     0,   0,   5'd0, 0,   5'd0, 5'd0, 5'd0, 0,   0,   1,    1,  1,  1,  1,  1};
    vecs[11] = '{"br_r0",     0,   1,   5'd0, 0,   5'd0, 5'd0, 5'd0, 0,   1,   0,    1,  1,  0,  1,  0};
    vecs[12] = '{"ld_nomatch",1,   1,   5'd8, 0,   5'd0, 5'd9, 5'd8, 0,   0,   0,    1,  1,  0,  1,  0};

    // Reset held: reset output values and counter cleared.
    set_idle();
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    step("reset", 0, 0, 1, 1, 1, 0);
    @(negedge Clk);
    Reset = 1'b0;
    step("post_reset", 1, 1, 0, 1, 0, 0);

    // Single-cycle vector table.
    for (int i = 0; i < 13; i++) begin
      @(negedge Clk);
      set_idle();
      EX_MemRead     = vecs[i].ex_memrd;
      EX_RegWrite    = vecs[i].ex_regwr;
      EX_WriteReg    = vecs[i].ex_wr;
      MEM_MemRead    = vecs[i].mem_memrd;
      MEM_WriteReg   = vecs[i].mem_wr;
      ID_Rs          = vecs[i].rs;
      ID_Rt          = vecs[i].rt;
      ID_UsesRt      = vecs[i].uses_rt;
      ID_IsBranch    = vecs[i].is_br;
      EX_BranchTaken = vecs[i].taken;
      step(vecs[i].name, vecs[i].e_pcw, vecs[i].e_ifw, vecs[i].e_flush,
           vecs[i].e_idw, vecs[i].e_bub, 1'b0);
    end

    // Branch after load: EX match, then the load moves to MEM behind a bubble.
    @(negedge Clk);
    set_idle();
    ID_IsBranch = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Rs = 5'd2;
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd9;
    step("brld_c1", 0, 0, 0, 1, 1, 0);
    @(negedge Clk);
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    MEM_MemRead = 1'b1; MEM_WriteReg = 5'd9;
    step("brld_c2", 0, 0, 0, 1, 1, 0);
    @(negedge Clk);
    MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
    step("brld_c3", 1, 1, 0, 1, 0, 0);

    // Mul/div: start cycle runs normally, then exactly 3 frozen cycles that ignore all inputs.
    @(negedge Clk);
    set_idle();
    EX_MulDivStart = 1'b1;
    step("md_start", 1, 1, 0, 1, 0, 0);
    @(negedge Clk);
    set_idle();
    step("md_w1", 0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
    step("md_w2", 0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    EX_MulDivStart = 1'b1;
    step("md_w3", 0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    set_idle();
    step("md_done", 1, 1, 0, 1, 0, 0);

    // Simultaneous taken branch and mul/div start: flush only, no wait.
    @(negedge Clk);
    set_idle();
    EX_BranchTaken = 1'b1; EX_MulDivStart = 1'b1;
    step("tk_md", 1, 1, 1, 1, 1, 0);
    @(negedge Clk);
    set_idle();
    step("tk_md_after", 1, 1, 0, 1, 0, 0);

    // Reset asserted in the 2nd wait cycle.
    @(negedge Clk);
    set_idle();
    EX_MulDivStart = 1'b1;
    step("rw_start", 1, 1, 0, 1, 0, 0);
    @(negedge Clk);
    set_idle();
    step("rw_w1", 0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    Reset = 1'b1;
    step("rw_reset", 0, 0, 1, 1, 1, 0);
    @(negedge Clk);
    Reset = 1'b0;
    step("rw_run", 1, 1, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, legal range 2..255: total EX-stage occupancy of a mul/div, in cycles.
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port EX_MemRead  in  1  load currently in EX (from EX_MEMCtrl).
REQ-005 SHALL have port EX_RegWrite  in  1  instruction in EX writes the register file (from EX_WBCtrl).
REQ-006 SHALL have port EX_WriteReg  in  5  destination register of EX, after the RegDst mux.
REQ-007 SHALL have port MEM_MemRead  in  1  load currently in MEM.
REQ-008 SHALL have port MEM_WriteReg  in  5  destination register of MEM.
REQ-009 SHALL have port ID_Rs  in  5  rs field (bits 25:21) of the instruction in ID.
REQ-010 SHALL have port ID_Rt  in  5  rt field (bits 20:16) of the instruction in ID.
REQ-011 SHALL have port ID_UsesRt  in  1  ID instruction reads rt as a source.
REQ-012 SHALL have port ID_IsBranch  in  1  ID instruction is a branch that compares operands in ID.
REQ-013 SHALL have port EX_BranchTaken  in  1  taken branch/jump redirect from EX.
REQ-014 SHALL have port EX_MulDivStart  in  1  mul/div entered EX this cycle.
REQ-015 SHALL have port PC_Write  out  1  PC update enable.
REQ-016 SHALL have port IFID_Write  out  1  IF/ID register load enable.
REQ-017 SHALL have port IFID_Flush  out  1  clear IF/ID to NOP.
REQ-018 SHALL have port IDEX_Write  out  1  ID/EX register load enable.
REQ-019 SHALL have port IDEX_Bubble  out  1  load zeroed WB/MEM/EX control into ID/EX.
REQ-020 SHALL have port Busy  out  1  multi-cycle mul/div wait in progress.
REQ-021 SHALL have port StallCycles  out  16  count of cycles with PC_Write=0.

Function
REQ-022 SHALL implement states RUN and MULDIV_WAIT, plus an 8-bit down-counter Cnt.
REQ-023 SHALL define the register-match rule as: a register is matched only when the compared field is nonzero and equal; register 0 never matches.
REQ-024 SHALL define LoadUse as: EX_MemRead, and EX_WriteReg matches ID_Rs, or ID_UsesRt and EX_WriteReg matches ID_Rt.
REQ-025 SHALL define BranchHaz as: ID_IsBranch, and either (EX_RegWrite with EX_WriteReg matching Rs/Rt) or (MEM_MemRead with MEM_WriteReg matching Rs/Rt).
REQ-026 SHALL evaluate hazards combinationally in the same cycle; there is no added latency.
REQ-027 SHALL, in RUN with EX_BranchTaken=1, drive PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Write=1 and IDEX_Bubble=1; flush takes priority and suppresses any stall.
REQ-028 SHALL, in RUN with no flush and (LoadUse or BranchHaz), drive PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Write=1 and IDEX_Bubble=1.
REQ-029 SHALL, in RUN with no hazard, drive PC_Write=1, IFID_Write=1, IDEX_Write=1, IFID_Flush=0 and IDEX_Bubble=0.
REQ-030 SHALL, in RUN with EX_MulDivStart=1 and no flush, transition to MULDIV_WAIT and load Cnt=MULDIV_CYCLES-1.
REQ-031 SHALL, in MULDIV_WAIT, drive PC_Write=0, IFID_Write=0, IDEX_Write=0, IFID_Flush=0, IDEX_Bubble=0 and Busy=1, and decrement Cnt each cycle.
REQ-032 SHALL return from MULDIV_WAIT to RUN on the cycle after Cnt reaches 1, so the front end is frozen for exactly MULDIV_CYCLES-1 cycles.
REQ-033 SHALL ignore EX_BranchTaken, EX_MulDivStart and hazard inputs while in MULDIV_WAIT.
REQ-034 SHALL let a simultaneous EX_BranchTaken and EX_MulDivStart in RUN resolve as flush only, with state remaining RUN.
REQ-035 SHALL increment StallCycles on each clock edge where Reset=0 and PC_Write=0, saturating at 16'hFFFF.

Reset
REQ-036 SHALL, on a clock edge with Reset=1, set state=RUN, Cnt=0 and StallCycles=0, including when MULDIV_WAIT is in progress.
REQ-037 SHALL, while Reset=1, drive PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Write=1, IDEX_Bubble=1 and Busy=0.

Verification
REQ-038 SHALL cover load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for 1 cycle; StallCycles +1.
REQ-039 SHALL cover the register-0 guard: same as REQ-038 with EX_WriteReg=0 and ID_Rs=0 -> no stall, PC_Write=1.
REQ-040 SHALL cover branch after load: ID_IsBranch=1, ID_Rt=9, ID_UsesRt=1, load to $9 in EX -> 2 consecutive stall cycles (EX match, then MEM match).
REQ-041 SHALL cover mul/div with MULDIV_CYCLES=4: EX_MulDivStart pulse -> Busy=1 and PC_Write=IDEX_Write=0 for exactly 3 cycles, then RUN.
REQ-042 SHALL cover flush priority: EX_BranchTaken=1 with LoadUse=1 -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, StallCycles unchanged.
REQ-043 SHALL cover reset mid-wait: Reset=1 in the 2nd MULDIV_WAIT cycle -> next cycle state=RUN, Busy=0, StallCycles=0.
